// File: rtl/tx_pkg.sv
// Shared types and constants for the RMII transmit frame arbiter.
package tx_pkg;

   localparam int unsigned DIBITS_PER_BYTE    = 4;
   localparam int unsigned DIBIT_W            = 2;
   localparam int unsigned BYTE_W             = DIBITS_PER_BYTE * DIBIT_W;
   localparam int unsigned DIBIT_CNT_W        = $clog2(DIBITS_PER_BYTE);
   localparam int unsigned IFG_DIBITS_DEFAULT = 48;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_IFG   = 2'd3
   } tx_arb_state_t;

   // One byte offered by a frame source.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } tx_byte_t;

endpackage

// File: rtl/dibit_serializer.sv
// Byte to dibit serializer: emits a loaded byte as four dibits, LSB dibit first.
// The shift register drains to zero after the final dibit, so dibit is 0 while idle.
module dibit_serializer
   import tx_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [BYTE_W-1:0]  load_data,
   output logic               active,
   output logic [DIBIT_W-1:0] dibit,
   output logic               done_c
);

   localparam logic [DIBIT_CNT_W-1:0] K_LAST = DIBIT_CNT_W'(DIBITS_PER_BYTE - 1);

   logic [BYTE_W-1:0]      sreg_q;
   logic [DIBIT_CNT_W-1:0] k_q;
   logic                   active_q;

   // A load on the final dibit restarts k at 0 with no idle cycle in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q   <= '0;
         k_q      <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         sreg_q   <= load_data;
         k_q      <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         sreg_q <= sreg_q >> DIBIT_W;
         k_q    <= k_q + DIBIT_CNT_W'(1);
         if (k_q == K_LAST) begin
            active_q <= 1'b0;
         end
      end
   end

   assign active = active_q;
   assign dibit  = sreg_q[DIBIT_W-1:0];
   assign done_c = active_q && (k_q == K_LAST);

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing the RMII transmit dibit path between two byte sources.
// Grants whole frames, serializes them LSB dibit first and enforces the inter-frame gap.
module tx_frame_arbiter
   import tx_pkg::*;
#(
   parameter int unsigned IFG_DIBITS = IFG_DIBITS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [BYTE_W-1:0]  req0_data,
   input  logic               req0_last,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [BYTE_W-1:0]  req1_data,
   input  logic               req1_last,
   output logic               req1_ready,
   output logic               axiov,
   output logic [DIBIT_W-1:0] axiod,
   output logic               grant,
   output logic               busy,
   output logic               underrun
);

   localparam int unsigned IFG_CNT_W = $clog2(IFG_DIBITS + 1);
   // The IDLE handshake cycle supplies the last idle dibit of the gap.
   localparam logic [IFG_CNT_W-1:0] IFG_LOAD = IFG_CNT_W'(IFG_DIBITS - 1);

   tx_arb_state_t        state_q, state_d;
   logic                 rr_q, rr_d;
   logic                 grant_q, grant_d;
   logic                 last_q, last_d;
   logic                 underrun_q, underrun_d;
   logic                 arb_en_q;
   logic [IFG_CNT_W-1:0] ifg_cnt_q, ifg_cnt_d;

   logic                 pick_c;
   logic                 src_sel_c;
   logic                 src_valid_c;
   tx_byte_t             src_c;
   logic                 take_c;
   logic                 ser_load_c;
   logic                 ser_done_c;

   // Source selection: arbitration choice in IDLE, owning source otherwise.
   assign pick_c      = (req0_valid && req1_valid) ? rr_q : req1_valid;
   assign src_sel_c   = (state_q == ST_IDLE) ? pick_c : grant_q;
   assign src_valid_c = src_sel_c ? req1_valid : req0_valid;

   always_comb begin
      src_c.last = src_sel_c ? req1_last : req0_last;
      src_c.data = src_sel_c ? req1_data : req0_data;
   end

   dibit_serializer u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ser_load_c),
      .load_data (src_c.data),
      .active    (axiov),
      .dibit     (axiod),
      .done_c    (ser_done_c)
   );

   // State and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_q       <= 1'b0;
         grant_q    <= 1'b0;
         last_q     <= 1'b0;
         underrun_q <= 1'b0;
         arb_en_q   <= 1'b0;
         ifg_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         underrun_q <= underrun_d;
         arb_en_q   <= 1'b1;
         ifg_cnt_q  <= ifg_cnt_d;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      last_d     = last_q;
      ifg_cnt_d  = ifg_cnt_q;
      underrun_d = 1'b0;
      take_c     = 1'b0;
      ser_load_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_en_q && src_valid_c) begin
               take_c     = 1'b1;
               ser_load_c = 1'b1;
               last_d     = src_c.last;
               grant_d    = src_sel_c;
               rr_d       = !src_sel_c;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ser_done_c) begin
               if (last_q) begin
                  state_d   = ST_IFG;
                  ifg_cnt_d = IFG_LOAD;
               end else if (src_valid_c) begin
                  take_c     = 1'b1;
                  ser_load_c = 1'b1;
                  last_d     = src_c.last;
               end else begin
                  // Starved before the last byte: the rest of the frame is still owed.
                  underrun_d = 1'b1;
                  state_d    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (src_valid_c) begin
               take_c = 1'b1;
               if (src_c.last) begin
                  state_d   = ST_IFG;
                  ifg_cnt_d = IFG_LOAD;
               end
            end
         end
         ST_IFG: begin
            if (ifg_cnt_q <= IFG_CNT_W'(1)) begin
               state_d = ST_IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q - IFG_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req0_ready = take_c && !src_sel_c;
   assign req1_ready = take_c && src_sel_c;
   assign grant      = grant_q;
   assign busy       = (state_q != ST_IDLE);
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed scenarios plus randomized frames
// checked against a frame-level model of grant order, frame contents and gap length.
module tb_tx_frame_arbiter;
   import tx_pkg::*;

   localparam int IFG = 48;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      int         gap;
   } src_item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_valid = '0;
   logic [1:0] req_last = '0;
   logic [7:0] req_data [2];
   logic       ready0, ready1;
   logic       axiov;
   logic [1:0] axiod;
   logic       grant, busy, underrun;

   always #10 clk = ~clk;

   tx_frame_arbiter #(.IFG_DIBITS(IFG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_valid[0]),
      .req0_data  (req_data[0]),
      .req0_last  (req_last[0]),
      .req0_ready (ready0),
      .req1_valid (req_valid[1]),
      .req1_data  (req_data[1]),
      .req1_last  (req_last[1]),
      .req1_ready (ready1),
      .axiov      (axiov),
      .axiod      (axiod),
      .grant      (grant),
      .busy       (busy),
      .underrun   (underrun)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Source side
   src_item_t  srcq [2][$];
   bit         have [2];
   bit         hs [2];
   int         gap_left [2];

   // Reference model: expected frames per source, rr history, gap bookkeeping
   logic [7:0] exp_b [2][$];
   int         exp_len [2][$];
   int         pend [2];
   bit         model_en = 1'b1;
   int         last_g = 1;
   bit         first_frame = 1'b1;

   // Monitor state and logs
   bit         in_frame = 1'b0;
   int         idle_cnt = 0;
   bit         v_at_ifg = 1'b0;
   bit         pv0 = 1'b0, pv1 = 1'b0;
   int         fr_grant = 0, fr_gap = 0;
   int         cur_d [$];
   int         grant_log [$];
   int         gap_log [$];
   int         len_log [$];
   int         dibit_log [$];
   int         ready_cnt [2];
   int         underrun_cnt = 0;
   int         both_ready_err = 0;
   int         axiod_err = 0;

   // Driver: presents the head item of each source queue, pops it after a handshake.
   initial forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (hs[s] && have[s] && srcq[s].size() > 0) begin
            void'(srcq[s].pop_front());
            have[s] = 1'b0;
         end
         hs[s] = 1'b0;
         if (!have[s] && srcq[s].size() > 0) begin
            have[s]     = 1'b1;
            gap_left[s] = srcq[s][0].gap;
         end
         if (have[s] && gap_left[s] > 0) begin
            gap_left[s]--;
            req_valid[s] = 1'b0;
         end else if (have[s]) begin
            req_valid[s] = 1'b1;
            req_data[s]  = srcq[s][0].data;
            req_last[s]  = srcq[s][0].last;
         end else begin
            req_valid[s] = 1'b0;
         end
      end
   end

   // Monitor and frame-level model check, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      hs[0] = req_valid[0] && ready0;
      hs[1] = req_valid[1] && ready1;
      if (!rst_n) begin
         in_frame    = 1'b0;
         idle_cnt    = 0;
         v_at_ifg    = 1'b0;
         first_frame = 1'b1;
         last_g      = 1;
         pv0         = 1'b0;
         pv1         = 1'b0;
      end else begin
         if (ready0 && ready1) both_ready_err++;
         if (ready0) ready_cnt[0]++;
         if (ready1) ready_cnt[1]++;
         if (underrun) underrun_cnt++;
         if (!axiov && axiod != 2'b00) axiod_err++;
         if (axiov) begin
            if (!in_frame) begin
               int exp_g;
               exp_g = (pv0 && pv1) ? (1 - last_g) : int'(pv1);
               if (model_en) begin
                  check_eq("rr_grant", grant, exp_g);
                  if (!first_frame) begin
                     if (v_at_ifg) check_eq("ifg_gap", idle_cnt, IFG);
                     else          check_eq("ifg_gap_late", int'(idle_cnt > IFG), 1);
                  end
               end
               last_g      = exp_g;
               first_frame = 1'b0;
               fr_grant    = grant;
               fr_gap      = idle_cnt;
               in_frame    = 1'b1;
               cur_d.delete();
            end
            cur_d.push_back(int'(axiod));
         end else begin
            if (in_frame) begin
               grant_log.push_back(fr_grant);
               gap_log.push_back(fr_gap);
               len_log.push_back(cur_d.size());
               foreach (cur_d[i]) dibit_log.push_back(cur_d[i]);
               if (model_en) begin
                  check_eq("frame_expected", int'(exp_len[fr_grant].size() > 0), 1);
                  if (exp_len[fr_grant].size() > 0) begin
                     int n;
                     n = exp_len[fr_grant].pop_front();
                     check_eq("frame_len", cur_d.size(), 4 * n);
                     for (int i = 0; i < n; i++) begin
                        int got;
                        int b;
                        b   = int'(exp_b[fr_grant].pop_front());
                        got = -1;
                        if (cur_d.size() >= 4 * i + 4)
                           got = cur_d[4*i] | (cur_d[4*i+1] << 2) | (cur_d[4*i+2] << 4) | (cur_d[4*i+3] << 6);
                        check_eq("frame_byte", got, b);
                     end
                  end
               end
               in_frame = 1'b0;
               idle_cnt = 0;
               v_at_ifg = 1'b0;
            end
            idle_cnt++;
            if (idle_cnt == IFG) v_at_ifg = req_valid[0] || req_valid[1];
         end
         pv0 = req_valid[0];
         pv1 = req_valid[1];
      end
   end

   task automatic push_byte(input int s, input logic [7:0] d, input logic l, input int gap);
      src_item_t it;
      it.data = d;
      it.last = l;
      it.gap  = gap;
      srcq[s].push_back(it);
      if (model_en) begin
         exp_b[s].push_back(d);
         pend[s]++;
         if (l) begin
            exp_len[s].push_back(pend[s]);
            pend[s] = 0;
         end
      end
   endtask

   task automatic clear_logs();
      grant_log.delete();
      gap_log.delete();
      len_log.delete();
      dibit_log.delete();
      ready_cnt[0] = 0;
      ready_cnt[1] = 0;
      underrun_cnt = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         srcq[s].delete();
         exp_b[s].delete();
         exp_len[s].delete();
         have[s] = 1'b0;
         hs[s]   = 1'b0;
         pend[s] = 0;
      end
      req_valid = '0;
      req_last  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (n < max_cycles &&
             !(srcq[0].size() == 0 && srcq[1].size() == 0 && !have[0] && !have[1] && !busy)) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, int'(n < max_cycles), 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp1 [8] = '{1, 1, 1, 1, 1, 1, 1, 3};
      int exp2 [8] = '{1, 1, 2, 2, 0, 3, 3, 0};
      int n;
      req_data[0] = '0;
      req_data[1] = '0;
      do_reset();

      // Reset state
      check_eq("rst_axiov", axiov, 0);
      check_eq("rst_axiod", axiod, 0);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_ready", int'({ready1, ready0}), 0);

      // 1: single two-byte frame from req0
      push_byte(0, 8'h55, 1'b0, 0);
      push_byte(0, 8'hD5, 1'b1, 0);
      wait_done("t1_done", 500);
      check_eq("t1_frames", grant_log.size(), 1);
      check_eq("t1_len", (len_log.size() > 0) ? len_log[0] : -1, 8);
      check_eq("t1_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
      for (int i = 0; i < 8; i++)
         check_eq("t1_dibit", (i < dibit_log.size()) ? dibit_log[i] : -1, exp1[i]);
      check_eq("t1_idle_after", int'(idle_cnt >= IFG), 1);

      // 2: simultaneous single-byte frames right after reset
      do_reset();
      push_byte(0, 8'hA5, 1'b1, 0);
      push_byte(1, 8'h3C, 1'b1, 0);
      wait_done("t2_done", 500);
      check_eq("t2_frames", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         check_eq("t2_grant0", grant_log[0], 0);
         check_eq("t2_grant1", grant_log[1], 1);
         check_eq("t2_gap", gap_log[1], IFG);
      end
      for (int i = 0; i < 8; i++)
         check_eq("t2_dibit", (i < dibit_log.size()) ? dibit_log[i] : -1, exp2[i]);

      // 3: both sources streaming single-byte frames
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         push_byte(0, 8'(8'h10 + i), 1'b1, 0);
         push_byte(1, 8'(8'h20 + i), 1'b1, 0);
      end
      wait_done("t3_done", 2000);
      check_eq("t3_frames", grant_log.size(), 6);
      for (int i = 0; i < 6; i++)
         check_eq("t3_grant", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
      for (int i = 1; i < 6; i++)
         check_eq("t3_gap", (i < gap_log.size()) ? gap_log[i] : -1, IFG);

      // 4: back-to-back bytes in one frame
      clear_logs();
      push_byte(1, 8'h01, 1'b0, 0);
      push_byte(1, 8'h02, 1'b0, 0);
      push_byte(1, 8'h03, 1'b1, 0);
      wait_done("t4_done", 500);
      check_eq("t4_frames", grant_log.size(), 1);
      check_eq("t4_len", (len_log.size() > 0) ? len_log[0] : -1, 12);
      check_eq("t4_ready1", ready_cnt[1], 3);
      check_eq("t4_ready0", ready_cnt[0], 0);

      // 5: underrun with drained remainder
      do_reset();
      model_en = 1'b0;
      push_byte(0, 8'hFF, 1'b0, 0);
      push_byte(0, 8'h11, 1'b0, 6);
      push_byte(0, 8'h22, 1'b1, 0);
      wait_done("t5_done", 500);
      check_eq("t5_frames", grant_log.size(), 1);
      check_eq("t5_len", (len_log.size() > 0) ? len_log[0] : -1, 4);
      for (int i = 0; i < 4; i++)
         check_eq("t5_dibit", (i < dibit_log.size()) ? dibit_log[i] : -1, 3);
      check_eq("t5_underrun", underrun_cnt, 1);
      check_eq("t5_ready0", ready_cnt[0], 3);
      check_eq("t5_idle_after", int'(idle_cnt >= IFG), 1);

      // 6: reset mid-frame
      do_reset();
      model_en = 1'b1;
      push_byte(1, 8'h9C, 1'b0, 0);
      push_byte(1, 8'h47, 1'b1, 0);
      n = 0;
      while (!axiov && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("t6_start", axiov, 1);
      @(posedge clk);
      @(posedge clk);
      #2;
      check_eq("t6_k2_dibit", axiod, 1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_axiov", axiov, 0);
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_ready1", ready1, 0);
      do_reset();
      push_byte(0, 8'h5A, 1'b1, 0);
      push_byte(1, 8'hC3, 1'b1, 0);
      wait_done("t6_done", 500);
      check_eq("t6_frames", grant_log.size(), 2);
      check_eq("t6_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // Randomized frames with random source idle time
      clear_logs();
      both_ready_err = 0;
      axiod_err      = 0;
      for (int f = 0; f < 30; f++) begin
         int s, len, gap;
         s   = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 4));
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
         for (int b = 0; b < len; b++)
            push_byte(s, 8'($urandom), 1'(b == len - 1), (b == 0) ? gap : 0);
      end
      wait_done("rnd_done", 20000);
      check_eq("rnd_underrun", underrun_cnt, 0);
      check_eq("rnd_exp_left", exp_len[0].size() + exp_len[1].size(), 0);
      check_eq("both_ready", both_ready_err, 0);
      check_eq("axiod_idle_zero", axiod_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
